registor_bank: RTL and testbench

REGISTOR_BANK -- requirements
Module: registor_bank

---
 rtl/registor_pkg.sv | 16 +
 rtl/registor_cell.sv | 40 ++++
 rtl/registor_bank.sv | 70 +++++++
 tb/tb_registor_bank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/registor_pkg.sv
// Shared operation encodings for the register bank and the datapath control.
package registor_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  // True when an executed inc/dec on 'value' rolls over the register range.
  function automatic logic op_wraps(input op_e op, input logic all_ones, input logic all_zero);
    return ((op == OP_INC) && all_ones) || ((op == OP_DEC) && all_zero);
  endfunction

endpackage

// File: rtl/registor_cell.sv
// One storage register with load and inc/dec/clear; reports rollover combinationally.
module registor_cell
  import registor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  op_e              op,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic all_ones;
  logic all_zero;

  assign all_ones = (q == {WIDTH{1'b1}});
  assign all_zero = (q == '0);

  // The bank never presents load and a live op together; load still takes priority.
  assign wrap = !load && op_wraps(op, all_ones, all_zero);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else begin
      case (op)
        OP_INC:  q <= q + WIDTH'(1);
        OP_DEC:  q <= q - WIDTH'(1);
        OP_CLR:  q <= '0;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/registor_bank.sv
// Register bank: write/modify decode, two combinational read ports, registered wrap pulse.
module registor_bank
  import registor_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  c_bus_in,
  input  logic              WE,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] op_sel,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic [WIDTH-1:0]  data_out_a,
  output logic [WIDTH-1:0]  data_out_b,
  output logic              zero_a,
  output logic              wrap
);

  logic [DEPTH-1:0] load_vec;
  logic [DEPTH-1:0] wrap_vec;
  op_e              cell_op [DEPTH];
  logic [WIDTH-1:0] q       [DEPTH];
  logic             collide;

  // A write to the same register as a modify wins; the modify is dropped entirely.
  assign collide = WE && (wr_sel == op_sel);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign load_vec[i] = WE && (wr_sel == ADDR_W'(i));
    assign cell_op[i]  = ((op_sel == ADDR_W'(i)) && !collide) ? op_e'(op) : OP_NONE;

    registor_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load_vec[i]),
      .data    (c_bus_in),
      .op      (cell_op[i]),
      .q       (q[i]),
      .wrap    (wrap_vec[i])
    );
  end

  // Selects beyond DEPTH match no register and read back as zero.
  always_comb begin
    data_out_a = '0;
    data_out_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_sel_a == ADDR_W'(i)) data_out_a = q[i];
      if (rd_sel_b == ADDR_W'(i)) data_out_b = q[i];
    end
  end

  assign zero_a = (data_out_a == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= |wrap_vec;
    end
  end

endmodule

// File: tb/tb_registor_bank.sv
// Scoreboard bench for registor_bank: DEPTH=8 and DEPTH=6 instances share one stimulus stream.
module tb_registor_bank;

  localparam int W = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  c_bus_in = '0;
  logic          we = 1'b0;
  logic [AW-1:0] wr_sel = '0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] op_sel = '0;
  logic [AW-1:0] rd_sel_a = '0;
  logic [AW-1:0] rd_sel_b = '0;

  logic [W-1:0] a0, b0, a1, b1;
  logic         z0, w0, z1, w1;

  always #5 clk = ~clk;

  registor_bank #(.WIDTH(W), .DEPTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .c_bus_in(c_bus_in), .WE(we), .wr_sel(wr_sel),
    .op(op), .op_sel(op_sel), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .data_out_a(a0), .data_out_b(b0), .zero_a(z0), .wrap(w0)
  );

  registor_bank #(.WIDTH(W), .DEPTH(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .c_bus_in(c_bus_in), .WE(we), .wr_sel(wr_sel),
    .op(op), .op_sel(op_sel), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .data_out_a(a1), .data_out_b(b1), .zero_a(z1), .wrap(w1)
  );

  typedef struct packed {
    logic [1:0][W-1:0] a;
    logic [1:0][W-1:0] b;
    logic [1:0]        z;
    logic [1:0]        w;
    int unsigned       idx;
  } exp_t;

  exp_t        sb[$];
  int unsigned mdl[2][64];
  int          dep[2] = '{8, 6};
  bit          wpend[2];
  int unsigned n_cyc = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic int unsigned rd(int k, int sel);
    return (sel < dep[k]) ? mdl[k][sel] : 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) mdl[k][i] = 0;
      wpend[k] = 1'b0;
    end
  endfunction

  function automatic void push_expect();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.a[k] = W'(rd(k, int'(rd_sel_a)));
      e.b[k] = W'(rd(k, int'(rd_sel_b)));
      e.z[k] = (rd(k, int'(rd_sel_a)) == 0);
      e.w[k] = wpend[k];
    end
    e.idx = n_cyc;
    sb.push_back(e);
  endfunction

  // Next register contents and wrap, from the arithmetic meaning of each command.
  function automatic void model_step();
    int unsigned old;
    int ws, os;
    ws = int'(wr_sel);
    os = int'(op_sel);
    for (int k = 0; k < 2; k++) begin
      bit wn = 1'b0;
      bit op_live = (op != 2'b00) && (os < dep[k]) && !(we && ws == os);
      if (op_live) begin
        old = mdl[k][os];
        case (op)
          2'b01: begin mdl[k][os] = (old + 1) % 65536; wn = (old == 65535); end
          2'b10: begin mdl[k][os] = (old + 65535) % 65536; wn = (old == 0); end
          default: mdl[k][os] = 0;
        endcase
      end
      if (we && ws < dep[k]) mdl[k][ws] = int'(c_bus_in);
      wpend[k] = wn;
    end
  endfunction

  task automatic cycle(input bit w, input int ws, input int d, input int o, input int os,
                       input int ra, input int rb);
    @(posedge clk);
    #1;
    we = w; wr_sel = AW'(ws); c_bus_in = W'(d); op = 2'(o); op_sel = AW'(os);
    rd_sel_a = AW'(ra); rd_sel_b = AW'(rb);
    n_cyc++;
    push_expect();
    model_step();
  endtask

  // Reset dropped mid-cycle while a write and an op are pending; both must be abandoned.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    we = 1'b1; wr_sel = 3'd1; c_bus_in = 16'd777; op = 2'b01; op_sel = 3'd2;
    rd_sel_a = 3'd1; rd_sel_b = 3'd2;
    #1;
    reset_n = 1'b0;
    model_reset();
    n_cyc++;
    push_expect();
    @(posedge clk);
    #1;
    n_cyc++;
    push_expect();
    #1;
    reset_n = 1'b1;
    we = 1'b0; op = 2'b00;
  endtask

  task automatic check(input string name, input int k, input int unsigned idx,
                       input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, idx, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("data_out_a", 0, e.idx, a0, e.a[0]);
        check("data_out_b", 0, e.idx, b0, e.b[0]);
        check("zero_a", 0, e.idx, W'(z0), W'(e.z[0]));
        check("wrap", 0, e.idx, W'(w0), W'(e.w[0]));
        check("data_out_a", 1, e.idx, a1, e.a[1]);
        check("data_out_b", 1, e.idx, b1, e.b[1]);
        check("zero_a", 1, e.idx, W'(z1), W'(e.z[1]));
        check("wrap", 1, e.idx, W'(w1), W'(e.w[1]));
      end
    end
  end

  initial begin : driver
    int d, guard;
    model_reset();
    #12;
    reset_n = 1'b1;

    cycle(0, 0, 0, 0, 0, 3, 7);
    cycle(1, 3, 463, 0, 0, 3, 3);
    cycle(0, 0, 0, 0, 0, 3, 3);
    cycle(1, 2, 65535, 0, 0, 2, 3);
    cycle(0, 0, 0, 1, 2, 2, 3);
    cycle(0, 0, 0, 0, 0, 2, 3);
    cycle(0, 0, 0, 0, 0, 2, 3);
    cycle(0, 0, 0, 2, 5, 5, 2);
    cycle(0, 0, 0, 3, 5, 5, 2);
    cycle(0, 0, 0, 0, 0, 5, 2);
    cycle(1, 4, 155, 1, 4, 4, 6);
    cycle(1, 6, 10, 0, 0, 4, 6);
    cycle(1, 4, 155, 1, 6, 4, 6);
    cycle(0, 0, 0, 0, 0, 4, 6);
    cycle(1, 7, 99, 0, 0, 7, 7);
    cycle(0, 0, 0, 0, 0, 6, 7);
    cycle(1, 1, 546, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 1, 1);
    mid_reset();
    cycle(0, 0, 0, 0, 0, 1, 2);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: d = 0;
        1: d = 65535;
        2: d = 1;
        default: d = int'($urandom_range(0, 65535));
      endcase
      cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), d, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
    cycle(0, 0, 0, 0, 0, 0, 1);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
